lcd_power_sequencer: RTL and testbench
======================================

// Module: lcd_power_sequencer
// PURPOSE
//  Controller sitting beside the 480x272 LCD timing generator on PixelClk. Sequences panel power-up/down
//  (DISP, timing-generator enable, backlight) and, while the panel is on, selects the active test pattern
//  (bars/square/solid...) with changes applied only on frame boundaries to avoid tearing.
// PARAMETERS
//  DISP_DLY      24'd90000  PixelClk cycles from DISP high to timing-generator release (~10 ms @ 9 MHz)
//  WARM_FRAMES   8'd4       full frames run with backlight off before BL is enabled (>=1)
//  OFF_DLY       24'd90000  cycles between timing-generator hold and DISP low on power-down
//  NUM_PATTERNS  4          number of selectable patterns (2..4); pattern_sel wraps modulo this
//  AUTO_FRAMES   16'd120    frames per pattern in auto-cycle mode (only with LCD_AUTOCYCLE_EN)
// PORTS
//  PixelClk     in   1   pixel clock; all logic on rising edge
//  nRST         in   1   asynchronous active-low reset
//  start_req    in   1   level: 1 = panel on requested, 0 = panel off requested
//  pattern_next in   1   single-cycle pulse: advance to next pattern at next frame start
//  vsync_in     in   1   LCD_VSYNC from timing generator (active low; falling edge = frame start)
//  tg_rst_n     out  1   active-low reset to timing generator (0 = held)
//  LCD_DISP     out  1   panel display-enable pin
//  LCD_BL       out  1   backlight enable
//  pattern_sel  out  2   active pattern index, 0..NUM_PATTERNS-1
//  frame_cnt    out  16  frames since generator release, wraps at 65535->0
//  ready        out  1   1 only in ON state
// BEHAVIOUR
//  Reset values: tg_rst_n=0, LCD_DISP=0, LCD_BL=0, pattern_sel=0, frame_cnt=0, ready=0, state=OFF.
//  Frame edge fe: vsync_in registered once; fe=1 when prev=1 and vsync_in=0; ignored while tg_rst_n=0.
//  FSM (registered outputs, take effect cycle after transition):
//   OFF   : all outputs low. start_req=1 -> DISP (delay counter cleared).
//   DISP  : LCD_DISP=1. counter counts to DISP_DLY-1 -> TG; start_req=0 -> TGOFF (abort).
//   TG    : tg_rst_n=1, frame_cnt cleared on entry; count WARM_FRAMES fe -> ON; start_req=0 -> TGOFF.
//   ON    : LCD_BL=1, ready=1. start_req=0 -> BLOFF.
//   BLOFF : LCD_BL=0, ready=0, generator still running; next fe -> TGOFF.
//   TGOFF : tg_rst_n=0, LCD_DISP=1; counter counts to OFF_DLY-1 -> OFF (LCD_DISP=0).
//   start_req re-asserted during BLOFF/TGOFF is ignored until OFF is reached (no short cycles).
//  frame_cnt: +1 on every fe while tg_rst_n=1; 16-bit wrap; holds value in OFF until next TG entry.
//  Pattern: pattern_next sets pending flag (any state except OFF). On fe in ON with pending (or
//   pattern_next in the same cycle as fe): pattern_sel <= (pattern_sel==NUM_PATTERNS-1)?0:+1, pending cleared.
//   Multiple pulses within one frame = one advance. Pending cleared on entry to OFF; pattern_sel kept.
//  Delay counters 24-bit, cleared on every state entry; no overflow possible for legal params.
//  nRST low at any time: immediate return to reset values, regardless of state.
// CONFIGURATION
//  LCD_AUTOCYCLE_EN defined: in ON, an internal 16-bit frame counter advances pattern_sel every
//   AUTO_FRAMES fe (cleared on entry to ON and on each advance); pattern_next still works, and a manual
//   advance also clears the auto counter; coincident auto+manual = single advance.
//  Not defined: pattern_sel changes only via pattern_next; auto counter logic absent.
// TESTING (bench params: DISP_DLY=10, WARM_FRAMES=2, OFF_DLY=5, NUM_PATTERNS=3, AUTO_FRAMES=4)
//  1 start_req=1 from OFF -> LCD_DISP=1 next cycle, tg_rst_n=1 10 cycles later, LCD_BL=ready=1 after 2nd fe.
//  2 In ON, start_req=0 -> LCD_BL=0 next cycle, tg_rst_n=0 at next fe, LCD_DISP=0 5 cycles later, state OFF.
//  3 In ON, 3 pattern_next pulses within one frame -> pattern_sel 0->1 at next fe only; 2 more frames w/ pulses -> 2,0 (wrap).
//  4 start_req dropped 4 cycles into DISP -> TGOFF, tg_rst_n stays 0, LCD_DISP low after 5 cycles; frame_cnt unchanged.
//  5 nRST pulsed low mid-ON -> all outputs 0 asynchronously; start_req=1 held -> full power-up repeats from DISP.
//  6 LCD_AUTOCYCLE_EN: ON with no pulses -> pattern_sel steps every 4 fe; pulse at frame 2 -> advance, next auto at +4 fe.

Source files
------------

// File: rtl/lcd_power_sequencer.sv
// lcd_power_sequencer: panel power-up/down sequencing and frame-aligned test-pattern selection.
// Optional macro LCD_AUTOCYCLE_EN enables automatic pattern cycling every AUTO_FRAMES frames while ON.
module lcd_power_sequencer #(
    parameter logic [23:0] DISP_DLY     = 24'd90000,
    parameter logic [7:0]  WARM_FRAMES  = 8'd4,
    parameter logic [23:0] OFF_DLY      = 24'd90000,
    parameter int          NUM_PATTERNS = 4,
    parameter logic [15:0] AUTO_FRAMES  = 16'd120
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        start_req,
    input  logic        pattern_next,
    input  logic        vsync_in,
    output logic        tg_rst_n,
    output logic        LCD_DISP,
    output logic        LCD_BL,
    output logic [1:0]  pattern_sel,
    output logic [15:0] frame_cnt,
    output logic        ready
);
    typedef enum logic [2:0] {S_OFF, S_DISP, S_TG, S_ON, S_BLOFF, S_TGOFF} state_t;

    localparam logic [23:0] DISP_LAST = DISP_DLY - 24'd1;
    localparam logic [23:0] WARM_LAST = 24'(WARM_FRAMES) - 24'd1;
    localparam logic [23:0] OFF_LAST  = OFF_DLY - 24'd1;
    localparam logic [1:0]  PAT_LAST  = 2'(NUM_PATTERNS - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [15:0] frame_q, frame_d;
    logic [1:0]  sel_q, sel_d;
    logic        pend_q, pend_d;
    logic        vsync_q;
    logic        tg_q, disp_q, on_q;
    logic        fe, on, adv, auto_hit, entered;

    // Frame edges only count while the generator is released, so a parked vsync cannot advance anything.
    assign fe      = vsync_q & ~vsync_in & tg_q;
    assign on      = state_q == S_ON;
    assign entered = state_d != state_q;
    assign adv     = on & fe & (pend_q | pattern_next | auto_hit);

`ifdef LCD_AUTOCYCLE_EN
    localparam logic [15:0] AUTO_LAST = AUTO_FRAMES - 16'd1;
    logic [15:0] auto_q, auto_d;
    assign auto_hit = on & fe & (auto_q == AUTO_LAST);
    assign auto_d   = ((state_d == S_ON && !on) || adv) ? 16'd0 : (on & fe) ? auto_q + 16'd1 : auto_q;
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) auto_q <= 16'd0;
        else       auto_q <= auto_d;
    end
`else
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF:   if (start_req) state_d = S_DISP;
            S_DISP:  if (!start_req) state_d = S_TGOFF;
                     else if (cnt_q == DISP_LAST) state_d = S_TG;
            S_TG:    if (!start_req) state_d = S_TGOFF;
                     else if (fe && cnt_q == WARM_LAST) state_d = S_ON;
            S_ON:    if (!start_req) state_d = S_BLOFF;
            S_BLOFF: if (fe) state_d = S_TGOFF;
            S_TGOFF: if (cnt_q == OFF_LAST) state_d = S_OFF;
            default: state_d = S_OFF;
        endcase
    end

    assign cnt_d   = entered ? 24'd0
                   : (state_q == S_DISP || state_q == S_TGOFF || (state_q == S_TG && fe)) ? cnt_q + 24'd1
                   : cnt_q;
    assign frame_d = (state_d == S_TG && state_q != S_TG) ? 16'd0 : fe ? frame_q + 16'd1 : frame_q;
    assign sel_d   = adv ? ((sel_q == PAT_LAST) ? 2'd0 : sel_q + 2'd1) : sel_q;
    assign pend_d  = (state_d == S_OFF || adv) ? 1'b0 : (pattern_next && state_q != S_OFF) ? 1'b1 : pend_q;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_OFF;
            cnt_q   <= 24'd0;
            frame_q <= 16'd0;
            sel_q   <= 2'd0;
            pend_q  <= 1'b0;
            vsync_q <= 1'b1;
            tg_q    <= 1'b0;
            disp_q  <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            vsync_q <= vsync_in;
            tg_q    <= state_d inside {S_TG, S_ON, S_BLOFF};
            disp_q  <= state_d != S_OFF;
            on_q    <= state_d == S_ON;
        end
    end

    assign tg_rst_n    = tg_q;
    assign LCD_DISP    = disp_q;
    assign LCD_BL      = on_q;
    assign ready       = on_q;
    assign pattern_sel = sel_q;
    assign frame_cnt   = frame_q;
endmodule

// File: tb/tb_lcd_power_sequencer.sv
// tb_lcd_power_sequencer: directed power-sequencing and pattern-selection checks with hand-computed expectations.
module tb_lcd_power_sequencer;
    logic        clk = 1'b0;
    logic        nrst, start_req, pattern_next, vsync;
    logic        tg_rst_n, lcd_disp, lcd_bl, ready;
    logic [1:0]  pattern_sel;
    logic [15:0] frame_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    lcd_power_sequencer #(
        .DISP_DLY(24'd10), .WARM_FRAMES(8'd2), .OFF_DLY(24'd5), .NUM_PATTERNS(3), .AUTO_FRAMES(16'd4)
    ) dut (
        .PixelClk(clk), .nRST(nrst), .start_req(start_req), .pattern_next(pattern_next),
        .vsync_in(vsync), .tg_rst_n(tg_rst_n), .LCD_DISP(lcd_disp), .LCD_BL(lcd_bl),
        .pattern_sel(pattern_sel), .frame_cnt(frame_cnt), .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        vsync = 1'b0;
        tick(1);
        vsync = 1'b1;
        tick(1);
    endtask

    task automatic pulse();
        pattern_next = 1'b1;
        tick(1);
        pattern_next = 1'b0;
        tick(1);
    endtask

    initial begin
        nrst = 1'b0; start_req = 1'b0; pattern_next = 1'b0; vsync = 1'b1;
        tick(2);
        check("reset_outs", {tg_rst_n, lcd_disp, lcd_bl, ready, pattern_sel, frame_cnt}, 0);
        nrst = 1'b1;
        tick(2);
        check("off_idle", {tg_rst_n, lcd_disp, lcd_bl, ready}, 0);

        // power-up
        start_req = 1'b1;
        tick(1);
        check("disp_on", {lcd_disp, tg_rst_n}, 2'b10);
        tick(9);
        check("tg_still_held", tg_rst_n, 0);
        tick(1);
        check("tg_release", tg_rst_n, 1);
        check("frame_clr", frame_cnt, 0);
        frame();
        check("warm1_bl", {lcd_bl, ready}, 0);
        check("warm1_frame", frame_cnt, 1);
        frame();
        check("on_bl_ready", {lcd_bl, ready}, 2'b11);
        check("on_frame", frame_cnt, 2);

        // pattern stepping on frame edges
        pulse(); pulse(); pulse();
        check("pat_wait_fe", pattern_sel, 0);
        frame();
        check("pat_multi_one", pattern_sel, 1);
        frame();
        check("pat_no_pulse", pattern_sel, 1);
        pulse(); frame();
        check("pat_to2", pattern_sel, 2);
        pulse(); frame();
        check("pat_wrap", pattern_sel, 0);
        pattern_next = 1'b1; vsync = 1'b0;
        tick(1);
        pattern_next = 1'b0; vsync = 1'b1;
        tick(1);
        check("pat_coincident", pattern_sel, 1);
        frame();
        check("pat_no_stale", pattern_sel, 1);
        check("frame_count", frame_cnt, 8);

        // power-down with ignored re-request
        start_req = 1'b0;
        tick(1);
        check("bloff_outs", {tg_rst_n, lcd_disp, lcd_bl, ready}, 4'b1100);
        tick(3);
        check("bloff_wait_fe", tg_rst_n, 1);
        vsync = 1'b0;
        tick(1);
        check("tgoff_outs", {tg_rst_n, lcd_disp}, 2'b01);
        check("tgoff_frame", frame_cnt, 9);
        vsync = 1'b1; start_req = 1'b1;
        tick(4);
        check("tgoff_disp_hold", lcd_disp, 1);
        tick(1);
        check("off_reached", {lcd_disp, tg_rst_n, ready}, 0);

        // restart, then abort in DISP
        tick(1);
        check("restart_disp", lcd_disp, 1);
        tick(3);
        check("disp_tg_held", tg_rst_n, 0);
        start_req = 1'b0;
        tick(1);
        check("abort_tgoff", {tg_rst_n, lcd_disp}, 2'b01);
        tick(4);
        check("abort_disp_hold", lcd_disp, 1);
        tick(1);
        check("abort_off", {lcd_disp, tg_rst_n}, 0);
        check("abort_frame", frame_cnt, 9);
        frame();
        check("fe_ignored_off", frame_cnt, 9);
        check("pat_kept_off", pattern_sel, 1);

        // async reset mid-ON
        start_req = 1'b1;
        tick(11);
        check("tg2_release", {tg_rst_n, frame_cnt}, 17'h10000);
        frame(); frame();
        check("on2_ready", {ready, frame_cnt}, 17'h10002);
        #2 nrst = 1'b0;
        #1 check("async_reset", {tg_rst_n, lcd_disp, lcd_bl, ready, pattern_sel, frame_cnt}, 0);
        @(negedge clk);
        nrst = 1'b1;
        tick(1);
        check("rst_redisp", {lcd_disp, tg_rst_n}, 2'b10);
        tick(9);
        check("rst_tg_held", tg_rst_n, 0);
        tick(1);
        check("rst_tg_rel", tg_rst_n, 1);
        frame(); frame();
        check("rst_on", {ready, lcd_bl, pattern_sel}, 4'b1100);

`ifdef LCD_AUTOCYCLE_EN
        frame(); frame(); frame();
        check("auto_wait", pattern_sel, 0);
        frame();
        check("auto_step", pattern_sel, 1);
        frame(); pulse(); frame();
        check("auto_manual", pattern_sel, 2);
        frame(); frame(); frame();
        check("auto_restart", pattern_sel, 2);
        frame();
        check("auto_wrap", pattern_sel, 0);
`else
        frame(); frame(); frame(); frame();
        check("no_auto", pattern_sel, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
